// File: rtl/lcd_bus_arbiter_pkg.sv
// Shared definitions for the character-LCD bus arbiter: FSM state encoding,
// HD44780 command bytes used by the requesters, and default bus timing
// (in CLOCK_50MHZ cycles).
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_EXEC  = 3'd3,
        ST_ACK   = 3'd4
    } lcd_arb_state_t;

    localparam logic [7:0] LCD_CMD_FUNC_SET   = 8'h38;
    localparam logic [7:0] LCD_CMD_ENTRY_MODE = 8'h07;
    localparam logic [7:0] LCD_CMD_DISP_CTRL  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_CMD_DDRAM_BASE = 8'h80;
    localparam logic [7:0] LCD_CMD_SHIFT      = 8'h18;

    localparam logic [31:0] LCD_DEF_SETUP_CYCLES     = 32'd2;
    localparam logic [31:0] LCD_DEF_PULSE_CYCLES     = 32'd12;
    localparam logic [31:0] LCD_DEF_EXEC_CYCLES      = 32'd2000;
    localparam logic [31:0] LCD_DEF_LONG_EXEC_CYCLES = 32'd82000;

    // One-hot acknowledge vector for a 2-requester grant index.
    function automatic logic [1:0] lcd_onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester handshake plus LCD pin bundle. The arbiter uses the slave view;
// the requester side (message logic / testbench) uses the master view.
interface lcd_bus_arbiter_if;

    logic [1:0]  REQ;
    logic [1:0]  REQ_RS;
    logic [15:0] REQ_DATA;
    logic [1:0]  REQ_LONG;
    logic [1:0]  ACK;
    logic        BUSY;
    logic [7:0]  LCD_DATA_BIT;
    logic        LCD_ENABLE;
    logic        LCD_REGISTER_SELECT;
    logic        LCD_READ_WRITE;

    modport slave (
        input  REQ, REQ_RS, REQ_DATA, REQ_LONG,
        output ACK, BUSY, LCD_DATA_BIT, LCD_ENABLE,
               LCD_REGISTER_SELECT, LCD_READ_WRITE
    );

    modport master (
        output REQ, REQ_RS, REQ_DATA, REQ_LONG,
        input  ACK, BUSY, LCD_DATA_BIT, LCD_ENABLE,
               LCD_REGISTER_SELECT, LCD_READ_WRITE
    );

endinterface

// File: rtl/lcd_bus_arbiter_pick.sv
// 2-way round-robin grant picker. On a tie the requester that was not
// granted last wins; a single requester always wins.
module lcd_rr_pick_2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       grant_o,
    output logic       valid_o
);

    // Combinational pick from the request vector and last-grant pointer.
    always_comb begin
        valid_o = |req_i;
        grant_o = 1'b0;
        case (req_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = ~ptr_i;
            default: grant_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Character-LCD bus arbiter: shares the write-only HD44780 bus between the
// init sequencer (port 0) and the text writer (port 1), generating the
// RS/DB setup, E pulse and execution wait for each single-byte write.
// Optional build macro LCD_ARB_STATS_EN adds XFER_COUNT and LAST_GRANT.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | bus quiet, sample requests, latch winner's RS/DB/LONG
//   ST_SETUP | RS/DB driven, E low, SETUP_CYCLES cycles
//   ST_PULSE | E high, PULSE_CYCLES cycles
//   ST_EXEC  | E low, wait EXEC_CYCLES or LONG_EXEC_CYCLES for the LCD
//   ST_ACK   | one-cycle ACK to the granted requester
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter logic [31:0] SETUP_CYCLES     = LCD_DEF_SETUP_CYCLES,
    parameter logic [31:0] PULSE_CYCLES     = LCD_DEF_PULSE_CYCLES,
    parameter logic [31:0] EXEC_CYCLES      = LCD_DEF_EXEC_CYCLES,
    parameter logic [31:0] LONG_EXEC_CYCLES = LCD_DEF_LONG_EXEC_CYCLES
) (
    input  logic             CLOCK_50MHZ,
    input  logic             BUTTON_SOUTH,
    lcd_bus_arbiter_if.slave bus
`ifdef LCD_ARB_STATS_EN
    ,
    output logic [15:0]      XFER_COUNT,
    output logic [0:0]       LAST_GRANT
`endif
);

    lcd_arb_state_t state_q, state_d;
    logic [31:0]    cnt_q, cnt_d;
    logic           grant_q, grant_d;
    logic           ptr_q, ptr_d;
    logic           rs_q, rs_d;
    logic           long_q, long_d;
    logic [7:0]     data_q, data_d;
    logic           en_q, en_d;
    logic           busy_q, busy_d;
    logic [1:0]     ack_q, ack_d;
    logic           pick_idx;
    logic           pick_vld;
    logic [31:0]    exec_last;

    lcd_rr_pick_2 u_pick (
        .req_i   (bus.REQ),
        .ptr_i   (ptr_q),
        .grant_o (pick_idx),
        .valid_o (pick_vld)
    );

    // The timer is a down-counter loaded with (duration - 1) on state entry.
    assign exec_last = long_q ? (LONG_EXEC_CYCLES - 32'd1) : (EXEC_CYCLES - 32'd1);

    // Next-state, timer and latch logic; pin values are derived from the
    // next state so every output comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        rs_d    = rs_q;
        long_d  = long_q;
        data_d  = data_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    ptr_d   = pick_idx;
                    rs_d    = bus.REQ_RS[pick_idx];
                    long_d  = bus.REQ_LONG[pick_idx];
                    data_d  = pick_idx ? bus.REQ_DATA[15:8] : bus.REQ_DATA[7:0];
                    cnt_d   = SETUP_CYCLES - 32'd1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 32'd0) begin
                    cnt_d   = PULSE_CYCLES - 32'd1;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == 32'd0) begin
                    cnt_d   = exec_last;
                    state_d = ST_EXEC;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 32'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_ACK: begin
                cnt_d   = 32'd0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = 32'd0;
                state_d = ST_IDLE;
            end
        endcase

        en_d   = (state_d == ST_PULSE);
        busy_d = (state_d != ST_IDLE);
        ack_d  = (state_d == ST_ACK) ? lcd_onehot2(grant_q) : 2'b00;
    end

    // State, timer, latched transfer and registered pin outputs.
    always_ff @(posedge CLOCK_50MHZ or posedge BUTTON_SOUTH) begin
        if (BUTTON_SOUTH) begin
            state_q <= ST_IDLE;
            cnt_q   <= 32'd0;
            grant_q <= 1'b0;
            ptr_q   <= 1'b1;
            rs_q    <= 1'b0;
            long_q  <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            rs_q    <= rs_d;
            long_q  <= long_d;
            data_q  <= data_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.LCD_DATA_BIT        = data_q;
    assign bus.LCD_REGISTER_SELECT = rs_q;
    assign bus.LCD_ENABLE          = en_q;
    assign bus.LCD_READ_WRITE      = 1'b0;
    assign bus.ACK                 = ack_q;
    assign bus.BUSY                = busy_q;

`ifdef LCD_ARB_STATS_EN
    logic [15:0] xfer_q;

    // Completed-transfer counter, stepping with the ACK pulse, saturating.
    always_ff @(posedge CLOCK_50MHZ or posedge BUTTON_SOUTH) begin
        if (BUTTON_SOUTH) begin
            xfer_q <= 16'h0000;
        end else if ((ack_d != 2'b00) && (xfer_q != 16'hFFFF)) begin
            xfer_q <= xfer_q + 16'h0001;
        end
    end

    assign XFER_COUNT = xfer_q;
    assign LAST_GRANT = ptr_q;
`endif

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed testbench for lcd_bus_arbiter with short timing
// (SETUP=2, PULSE=12, EXEC=20, LONG_EXEC=100).
module tb_lcd_bus_arbiter;
    import lcd_pkg::*;

    localparam logic [31:0] T_SETUP = 32'd2;
    localparam logic [31:0] T_PULSE = 32'd12;
    localparam logic [31:0] T_EXEC  = 32'd20;
    localparam logic [31:0] T_LONG  = 32'd100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_bus_arbiter_if bus ();

`ifdef LCD_ARB_STATS_EN
    logic [15:0] xfer;
    logic [0:0]  lg;
`endif

    lcd_bus_arbiter #(
        .SETUP_CYCLES     (T_SETUP),
        .PULSE_CYCLES     (T_PULSE),
        .EXEC_CYCLES      (T_EXEC),
        .LONG_EXEC_CYCLES (T_LONG)
    ) dut (
        .CLOCK_50MHZ  (clk),
        .BUTTON_SOUTH (rst),
        .bus          (bus)
`ifdef LCD_ARB_STATS_EN
        ,
        .XFER_COUNT   (xfer),
        .LAST_GRANT   (lg)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] msg [14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                             8'h53, 8'h70, 8'h61, 8'h72, 8'h74, 8'h61, 8'h6E};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    task automatic drive_quiet();
        bus.REQ      = 2'b00;
        bus.REQ_RS   = 2'b00;
        bus.REQ_DATA = 16'h0000;
        bus.REQ_LONG = 2'b00;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (bus.BUSY !== 1'b0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (bus.BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: got BUSY=%b expected 0", bus.BUSY);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_quiet();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.LCD_DATA_BIT, bus.LCD_ENABLE, bus.LCD_REGISTER_SELECT,
             bus.LCD_READ_WRITE, bus.ACK, bus.BUSY} !== 13'h0000) begin
            n_err++;
            $display("FAIL reset_outputs: got DB=%h E=%b RS=%b RW=%b ACK=%b BUSY=%b expected all 0",
                     bus.LCD_DATA_BIT, bus.LCD_ENABLE, bus.LCD_REGISTER_SELECT,
                     bus.LCD_READ_WRITE, bus.ACK, bus.BUSY);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.LCD_ENABLE, bus.ACK, bus.BUSY} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_release_idle: got E/ACK/BUSY=%b expected 0000",
                     {bus.LCD_ENABLE, bus.ACK, bus.BUSY});
        end
    endtask

    task automatic test_single();
        logic       exp_e;
        logic [1:0] exp_ack;
        logic       exp_busy;
        @(posedge clk); #1;
        bus.REQ_RS   = 2'b00;
        bus.REQ_LONG = 2'b00;
        bus.REQ_DATA = {8'h00, LCD_CMD_FUNC_SET};
        bus.REQ      = 2'b01;
        for (int cyc = 0; cyc <= 37; cyc++) begin
            @(negedge clk);
            exp_e    = (cyc >= 3 && cyc <= 14);
            exp_ack  = (cyc == 35) ? 2'b01 : 2'b00;
            exp_busy = (cyc >= 1 && cyc <= 35);
            n_cmp++;
            if ({bus.LCD_ENABLE, bus.ACK, bus.BUSY} !== {exp_e, exp_ack, exp_busy}) begin
                n_err++;
                $display("FAIL single_cyc%0d: got E/ACK/BUSY=%b expected %b", cyc,
                         {bus.LCD_ENABLE, bus.ACK, bus.BUSY}, {exp_e, exp_ack, exp_busy});
            end
            if (cyc >= 1) begin
                n_cmp++;
                if ({bus.LCD_REGISTER_SELECT, bus.LCD_DATA_BIT} !== 9'h038) begin
                    n_err++;
                    $display("FAIL single_bus_cyc%0d: got RS=%b DB=%h expected RS=0 DB=38", cyc,
                             bus.LCD_REGISTER_SELECT, bus.LCD_DATA_BIT);
                end
            end
            if (cyc == 35) bus.REQ = 2'b00;
        end
    endtask

    task automatic test_long();
        int         e_cnt, e_fall, ack_cyc;
        logic [1:0] ack_val;
        logic       prev_e;
        e_cnt = 0; e_fall = -1; ack_cyc = -1; ack_val = 2'b00; prev_e = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        bus.REQ_RS   = 2'b00;
        bus.REQ_LONG = 2'b10;
        bus.REQ_DATA = {LCD_CMD_CLEAR, 8'h00};
        bus.REQ      = 2'b10;
        for (int cyc = 0; cyc < 130; cyc++) begin
            @(negedge clk);
            if (bus.LCD_ENABLE === 1'b1) e_cnt++;
            if (prev_e && bus.LCD_ENABLE === 1'b0 && e_fall < 0) e_fall = cyc;
            if (bus.ACK !== 2'b00 && ack_cyc < 0) begin
                ack_cyc = cyc;
                ack_val = bus.ACK;
                bus.REQ = 2'b00;
            end
            if (cyc == 1) begin
                n_cmp++;
                if ({bus.LCD_REGISTER_SELECT, bus.LCD_DATA_BIT} !== 9'h001) begin
                    n_err++;
                    $display("FAIL long_bus: got RS=%b DB=%h expected RS=0 DB=01",
                             bus.LCD_REGISTER_SELECT, bus.LCD_DATA_BIT);
                end
            end
            prev_e = bus.LCD_ENABLE;
        end
        bus.REQ      = 2'b00;
        bus.REQ_LONG = 2'b00;
        n_cmp++;
        if (e_cnt != 12) begin
            n_err++;
            $display("FAIL long_e_width: got %0d expected 12", e_cnt);
        end
        n_cmp++;
        if (e_fall != 15) begin
            n_err++;
            $display("FAIL long_e_fall: got cycle %0d expected 15", e_fall);
        end
        n_cmp++;
        if (ack_cyc != 115) begin
            n_err++;
            $display("FAIL long_ack_cycle: got %0d expected 115", ack_cyc);
        end
        n_cmp++;
        if (ack_val !== 2'b10) begin
            n_err++;
            $display("FAIL long_ack_value: got %b expected 10", ack_val);
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_db  [4];
        logic       exp_rs  [4];
        logic [1:0] exp_ack [4];
        int         n_e, n_a;
        logic       dbl, prev_e;
        exp_db  = '{8'h41, 8'h18, 8'h41, 8'h18};
        exp_rs  = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
        n_e = 0; n_a = 0; dbl = 1'b0; prev_e = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.REQ_DATA = {LCD_CMD_SHIFT, 8'h41};
        bus.REQ_RS   = 2'b01;
        bus.REQ_LONG = 2'b00;
        bus.REQ      = 2'b11;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (bus.LCD_ENABLE === 1'b1 && !prev_e) begin
                if (n_e < 4) begin
                    n_cmp++;
                    if ({bus.LCD_REGISTER_SELECT, bus.LCD_DATA_BIT} !== {exp_rs[n_e], exp_db[n_e]}) begin
                        n_err++;
                        $display("FAIL contention_bus%0d: got RS=%b DB=%h expected RS=%b DB=%h", n_e,
                                 bus.LCD_REGISTER_SELECT, bus.LCD_DATA_BIT, exp_rs[n_e], exp_db[n_e]);
                    end
                end
                n_e++;
            end
            if (bus.ACK === 2'b11) dbl = 1'b1;
            if (bus.ACK !== 2'b00) begin
                if (n_a < 4) begin
                    n_cmp++;
                    if (bus.ACK !== exp_ack[n_a]) begin
                        n_err++;
                        $display("FAIL contention_ack%0d: got %b expected %b", n_a, bus.ACK, exp_ack[n_a]);
                    end
                end
                n_a++;
                if (n_a == 4) bus.REQ = 2'b00;
            end
            prev_e = bus.LCD_ENABLE;
        end
        bus.REQ = 2'b00;
        n_cmp++;
        if (n_a != 4 || n_e != 4) begin
            n_err++;
            $display("FAIL contention_count: got acks=%0d pulses=%0d expected 4 and 4", n_a, n_e);
        end
        n_cmp++;
        if (dbl !== 1'b0) begin
            n_err++;
            $display("FAIL contention_double_ack: got 1 expected 0");
        end
    endtask

    task automatic test_withdrawal();
        int   n_e, a0_cyc;
        logic a1, db_bad, prev_e;
        n_e = 0; a0_cyc = -1; a1 = 1'b0; db_bad = 1'b0; prev_e = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        bus.REQ_RS   = 2'b00;
        bus.REQ_LONG = 2'b00;
        bus.REQ_DATA = {LCD_CMD_DDRAM_BASE, LCD_CMD_DISP_CTRL};
        bus.REQ      = 2'b01;
        for (int cyc = 0; cyc < 90; cyc++) begin
            @(negedge clk);
            if (bus.LCD_ENABLE === 1'b1 && !prev_e) n_e++;
            if (bus.ACK === 2'b01 && a0_cyc < 0) a0_cyc = cyc;
            if (bus.ACK[1] !== 1'b0) a1 = 1'b1;
            if (cyc >= 1 && cyc <= 35 &&
                {bus.LCD_REGISTER_SELECT, bus.LCD_DATA_BIT} !== 9'h00C) db_bad = 1'b1;
            if (cyc == 40) begin
                n_cmp++;
                if (bus.BUSY !== 1'b0) begin
                    n_err++;
                    $display("FAIL withdraw_busy: got %b expected 0", bus.BUSY);
                end
            end
            if (cyc == 5) begin
                bus.REQ           = 2'b00;
                bus.REQ_DATA[7:0] = 8'hFF;
                bus.REQ_RS        = 2'b11;
            end
            if (cyc == 20) bus.REQ = 2'b10;
            if (cyc == 25) bus.REQ = 2'b00;
            prev_e = bus.LCD_ENABLE;
        end
        bus.REQ_RS = 2'b00;
        n_cmp++;
        if (a0_cyc != 35) begin
            n_err++;
            $display("FAIL withdraw_ack0: got cycle %0d expected 35", a0_cyc);
        end
        n_cmp++;
        if (a1 !== 1'b0) begin
            n_err++;
            $display("FAIL withdraw_ack1: got 1 expected 0");
        end
        n_cmp++;
        if (n_e != 1) begin
            n_err++;
            $display("FAIL withdraw_pulses: got %0d expected 1", n_e);
        end
        n_cmp++;
        if (db_bad !== 1'b0) begin
            n_err++;
            $display("FAIL withdraw_latched_bus: got changed expected DB=0C RS=0 held");
        end
    endtask

    task automatic test_back_to_back();
        int   n_e, n_a, last_ack;
        logic gap_bad, prev_e, prev_busy;
        n_e = 0; n_a = 0; last_ack = -1; gap_bad = 1'b0; prev_e = 1'b0; prev_busy = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        bus.REQ_RS   = 2'b01;
        bus.REQ_LONG = 2'b00;
        bus.REQ_DATA = {8'h00, msg[0]};
        bus.REQ      = 2'b01;
        for (int cyc = 0; cyc < 560; cyc++) begin
            @(negedge clk);
            if (bus.LCD_ENABLE === 1'b1 && !prev_e) begin
                if (n_e < 14) begin
                    n_cmp++;
                    if ({bus.LCD_REGISTER_SELECT, bus.LCD_DATA_BIT} !== {1'b1, msg[n_e]}) begin
                        n_err++;
                        $display("FAIL b2b_char%0d: got RS=%b DB=%h expected RS=1 DB=%h", n_e,
                                 bus.LCD_REGISTER_SELECT, bus.LCD_DATA_BIT, msg[n_e]);
                    end
                end
                n_e++;
            end
            if (last_ack >= 0 && cyc == last_ack + 1 && bus.BUSY !== 1'b0) gap_bad = 1'b1;
            if (!prev_busy && bus.BUSY === 1'b1 && last_ack >= 0 && (cyc - last_ack) != 2)
                gap_bad = 1'b1;
            if (bus.ACK === 2'b01) begin
                n_a++;
                last_ack = cyc;
                if (n_a < 14) bus.REQ_DATA[7:0] = msg[n_a];
                else          bus.REQ = 2'b00;
            end
            prev_e    = bus.LCD_ENABLE;
            prev_busy = bus.BUSY;
        end
        bus.REQ    = 2'b00;
        bus.REQ_RS = 2'b00;
        n_cmp++;
        if (n_e != 14) begin
            n_err++;
            $display("FAIL b2b_pulses: got %0d expected 14", n_e);
        end
        n_cmp++;
        if (n_a != 14) begin
            n_err++;
            $display("FAIL b2b_acks: got %0d expected 14", n_a);
        end
        n_cmp++;
        if (gap_bad !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle_gap: got wrong gap expected one idle cycle");
        end
        n_cmp++;
        if (last_ack != 503) begin
            n_err++;
            $display("FAIL b2b_last_ack: got cycle %0d expected 503", last_ack);
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic seen;
        seen = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        bus.REQ_RS   = 2'b00;
        bus.REQ_LONG = 2'b00;
        bus.REQ_DATA = {8'h00, LCD_CMD_ENTRY_MODE};
        bus.REQ      = 2'b01;
        for (int cyc = 0; cyc <= 6; cyc++) @(negedge clk);
        n_cmp++;
        if (bus.LCD_ENABLE !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pulse_pre: got E=%b expected 1", bus.LCD_ENABLE);
        end
        @(posedge clk); #3;
        rst     = 1'b1;
        bus.REQ = 2'b00;
        #1;
        n_cmp++;
        if ({bus.LCD_ENABLE, bus.BUSY, bus.ACK} !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_pulse_e_drop: got E/BUSY/ACK=%b expected 0000",
                     {bus.LCD_ENABLE, bus.BUSY, bus.ACK});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (bus.ACK !== 2'b00 || bus.LCD_ENABLE !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL rst_pulse_no_ack: got activity expected none");
        end
    endtask

    initial begin
        drive_quiet();
        test_reset();
        test_single();
        test_long();
        test_contention();
        test_withdrawal();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
Shares the Spartan-3AN starter-kit character LCD (HD44780-style, 8-bit bus, write-only) between two requesters: an init/config sequencer (port 0) and a text/shift writer (port 1). Each transfer is one RS/DB write. The block arbitrates round-robin, drives the LCD pins and generates the setup / enable-pulse / execution-wait timing. It acknowledges each requester on completion. It sits between the top-level LCD pins and the message logic, so the requesters no longer own the pins.

Parameters:
SETUP_CYCLES, 32'd2, cycles RS/DB are stable before LCD_ENABLE rises (must be >=1)
PULSE_CYCLES, 32'd12, cycles LCD_ENABLE is held high (must be >=1)
EXEC_CYCLES, 32'd2000, post-pulse wait for a normal command or character (must be >=1)
LONG_EXEC_CYCLES, 32'd82000, post-pulse wait when the request's LONG flag is set (clear/home)

Ports:
CLOCK_50MHZ  input  1  system clock
BUTTON_SOUTH  input  1  reset, asynchronous, active-high
REQ  input  2  per-requester level request, bit i = requester i
REQ_RS  input  2  register select per requester (0 = command, 1 = data)
REQ_DATA  input  16  byte per requester, [7:0] = requester 0, [15:8] = requester 1
REQ_LONG  input  2  per requester: select LONG_EXEC_CYCLES
ACK  output  2  one-cycle completion pulse per requester
BUSY  output  1  high in every state except IDLE
LCD_DATA_BIT  output  8  LCD DB[7:0]
LCD_ENABLE  output  1  LCD E
LCD_REGISTER_SELECT  output  1  LCD RS
LCD_READ_WRITE  output  1  LCD RW, constant 0

Behaviour:
- Reset values (asynchronous): state IDLE, LCD_ENABLE 0, LCD_READ_WRITE 0, LCD_REGISTER_SELECT 0, LCD_DATA_BIT 8'h00, ACK 2'b00, BUSY 0, last-grant pointer = 1 (so requester 0 wins the first tie), counter 0.
- All outputs are registered. No combinational path from any input to any output.
- FSM states:
  - IDLE: if any REQ bit is set, latch grant index, RS, DATA and LONG for the granted requester. Go to SETUP next cycle.
  - SETUP: LCD_REGISTER_SELECT and LCD_DATA_BIT show the latched values from the first SETUP cycle. Lasts exactly SETUP_CYCLES cycles, then go to PULSE.
  - PULSE: LCD_ENABLE = 1 for exactly PULSE_CYCLES cycles, then go to EXEC.
  - EXEC: LCD_ENABLE = 0. RS/DB are held. Lasts EXEC_CYCLES, or LONG_EXEC_CYCLES if latched LONG=1. Then go to ACK.
  - ACK: ACK[grant] = 1 for exactly one cycle. RS/DB are still held. Next state is IDLE.
- Latency: if REQ is sampled in IDLE at cycle 0, ACK is high in cycle SETUP+PULSE+EXEC+1. The earliest next grant is sampled in the following cycle.
- Arbitration:
  - If only one REQ bit is set, that requester is granted.
  - If both are set, the requester not equal to the last-grant pointer wins.
  - The pointer updates on grant.
- Requester protocol:
  - Hold REQ, REQ_RS, REQ_DATA and REQ_LONG stable until ACK.
  - On the edge that ends the ACK cycle, drop REQ or present the next transfer. IDLE samples in the cycle after ACK, so no double issue occurs.
- REQ dropped before grant: no transfer, no ACK.
- REQ dropped after grant: ignored. The transfer completes and ACK is still issued.
- Input changes after latch have no effect on the bus.
- Reset mid-transfer: LCD_ENABLE falls immediately and ACK is never issued. Requesters restart on their own reset.
- Counter is 32 bits and compares with ==, with no wrap for the default values.

Optional Feature:
LCD_ARB_STATS_EN
- Defined: adds output port XFER_COUNT [15:0]. It increments in each ACK cycle, saturates at 16'hFFFF and resets to 0. It adds output LAST_GRANT [0:0] = the last-grant pointer.
- Undefined: neither port exists, with no logic and no behaviour change.

Decomposition:
- Shared package lcd_pkg holds:
  - state encoding constants (IDLE, SETUP, PULSE, EXEC, ACK)
  - HD44780 command constants (8'h38 function set, 8'h07 entry mode, 8'h0c display control, 8'h01 clear, 8'h80 DDRAM base, 8'h18 shift)
  - default timing values
- One natural sub-module: lcd_rr_pick_2, a 2-way round-robin grant picker (REQ, pointer -> grant index, valid). The FSM, timer and pin registers stay in lcd_bus_arbiter.

Test Plan:
- Reset: hold BUTTON_SOUTH high -> all outputs 0, BUSY 0. Assert reset during PULSE -> LCD_ENABLE 0 in the same cycle, no ACK afterwards.
- Single write (SETUP=2, PULSE=12, EXEC=20): REQ=01, RS=0, DATA=8'h38 at cycle 0 -> DB=8'h38 and RS=0 from cycle 1; E high cycles 3..14; ACK=01 at cycle 35 only; BUSY low at cycle 36.
- Long wait: requester 1, RS=0, DATA=8'h01, LONG=1, LONG_EXEC=100 -> ACK=10 exactly 100 cycles after E falls, with E high for 12 cycles.
- Contention: both REQ held continuously after reset, requester 0 DATA=8'h41 with RS=1, requester 1 DATA=8'h18 -> bus order 41,18,41,18, ACK alternating 01,10,01,10, never two ACKs in one cycle.
- Request withdrawal: REQ[1] pulsed while requester 0's transfer is in EXEC and dropped before IDLE -> no transfer and no ACK for requester 1. REQ[0] dropped during PULSE -> transfer completes and ACK=01 still issued.
- Back-to-back: requester 0 issues 14 characters (RS=1) by updating REQ_DATA on each ACK -> exactly 14 E pulses, DB sequence matches the input order, one idle cycle between ACK and the next SETUP.
